// File: rtl/pio_seq_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state type for pio_seq_ctrl.
package pio_seq_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_DWELL  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_RUN    = 0;
    localparam int CTRL_LOOP   = 1;
    localparam int CTRL_IRQEN  = 2;
    localparam int CTRL_FLUSH  = 31;

    localparam int ST_BUSY     = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_FULL     = 2;
    localparam int ST_DONE     = 3;
    localparam int ST_OVF      = 8;
    localparam int ST_CNT_LSB  = 12;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_e;

endpackage

// File: rtl/pio_seq_dwell_cnt.sv
// Loadable down-counter; tc_o pulses while enabled on the final cycle of a dwell period.
module pio_seq_dwell_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (en_i && cnt_q != '0)
            cnt_q <= cnt_q - W'(1);
    end

    assign tc_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/pio_seq_ctrl.sv
// Avalon-MM pattern sequencer: buffered words played on out_port with programmable dwell.
// Optional macro PIO_SEQ_IRQ_EN enables the done interrupt and the CTRL irq_en bit.
module pio_seq_ctrl
    import pio_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [CW-1:0]               count_q, count_d;
    logic [WIDTH-1:0]            out_q, out_d;
    logic [15:0]                 dwell_q, dwell_d;
    logic                        run_q, run_d, loop_q, loop_d, irqen_q, irqen_d;
    logic                        done_q, done_d, ovf_q, ovf_d;
    logic [DEPTH-1:0][WIDTH-1:0] pbuf_q;

    logic        wr_stb, tc, dwell_load, buf_we, last_word;
    logic        done_set, done_clr, ovf_set, ovf_clr;
    logic [15:0] dwell_val;
    logic        unused_wd;

    assign wr_stb    = chipselect && !write_n;
    assign last_word = ({1'b0, idx_q} == (count_q - CW'(1)));
    assign dwell_val = (dwell_q == 16'd0) ? 16'd1 : dwell_q;
    assign unused_wd = ^writedata[30:16];

    pio_seq_dwell_cnt #(.W(16)) u_dwell (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (dwell_load),
        .load_val_i (dwell_val),
        .en_i       (state_q == S_PLAY),
        .tc_o       (tc)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        out_d      = out_q;
        dwell_d    = dwell_q;
        run_d      = run_q;
        loop_d     = loop_q;
        irqen_d    = irqen_q;
        dwell_load = 1'b0;
        buf_we     = 1'b0;
        done_set   = 1'b0;
        done_clr   = 1'b0;
        ovf_set    = 1'b0;
        ovf_clr    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_q) begin
                    if (count_q != '0) begin
                        state_d    = S_PLAY;
                        idx_d      = '0;
                        out_d      = pbuf_q[0];
                        dwell_load = 1'b1;
                    end else begin
                        run_d    = 1'b0;
                        done_set = 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (!run_q) begin
                    state_d = S_IDLE;
                end else if (tc) begin
                    if (!last_word) begin
                        idx_d      = idx_q + IW'(1);
                        out_d      = pbuf_q[idx_q + IW'(1)];
                        dwell_load = 1'b1;
                    end else if (loop_q) begin
                        idx_d      = '0;
                        out_d      = pbuf_q[0];
                        dwell_load = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        run_d    = 1'b0;
                        done_set = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes are applied after the FSM so a register write overrides it.
        if (wr_stb) begin
            case (address)
                ADDR_DATA: begin
                    if (count_q < DEPTH_C) begin
                        buf_we  = 1'b1;
                        count_d = count_q + CW'(1);
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                ADDR_DWELL: dwell_d = writedata[15:0];
                ADDR_CTRL: begin
                    if (writedata[CTRL_FLUSH]) begin
                        count_d    = '0;
                        idx_d      = '0;
                        state_d    = S_IDLE;
                        run_d      = 1'b0;
                        out_d      = out_q;
                        done_set   = 1'b0;
                        dwell_load = 1'b0;
                    end else begin
                        run_d  = writedata[CTRL_RUN];
                        loop_d = writedata[CTRL_LOOP];
`ifdef PIO_SEQ_IRQ_EN
                        irqen_d = writedata[CTRL_IRQEN];
`endif
                    end
                end
                default: begin
                    done_clr = writedata[ST_DONE];
                    ovf_clr  = writedata[ST_OVF];
                end
            endcase
        end

        done_d = (done_q && !done_clr) || done_set;
        ovf_d  = (ovf_q && !ovf_clr) || ovf_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            out_q   <= '0;
            dwell_q <= '0;
            run_q   <= 1'b0;
            loop_q  <= 1'b0;
            irqen_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            out_q   <= out_d;
            dwell_q <= dwell_d;
            run_q   <= run_d;
            loop_q  <= loop_d;
            irqen_q <= irqen_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Pattern storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (buf_we)
            pbuf_q[count_q[IW-1:0]] <= writedata[WIDTH-1:0];
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:  readdata = 32'(out_q);
            ADDR_DWELL: readdata = 32'(dwell_q);
            ADDR_CTRL: begin
                readdata[CTRL_RUN]   = run_q;
                readdata[CTRL_LOOP]  = loop_q;
                readdata[CTRL_IRQEN] = irqen_q;
            end
            default: begin
                readdata[ST_BUSY]  = (state_q == S_PLAY);
                readdata[ST_EMPTY] = (count_q == '0);
                readdata[ST_FULL]  = (count_q == DEPTH_C);
                readdata[ST_DONE]  = done_q;
                readdata[ST_OVF]   = ovf_q;
                readdata[ST_CNT_LSB +: 4] = 4'(count_q);
            end
        endcase
    end

    assign out_port = out_q;

`ifdef PIO_SEQ_IRQ_EN
    assign irq = done_q && irqen_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_pio_seq_ctrl.sv
// Directed self-checking bench for pio_seq_ctrl (DEPTH=8, WIDTH=16).
module tb_pio_seq_ctrl;

    logic        clk, reset_n, chipselect, write_n, irq;
    logic [1:0]  address;
    logic [31:0] writedata, readdata, rv;
    logic [15:0] out_port;
    logic [15:0] pat [3];
    logic [31:0] exp_v;

    int checks = 0;
    int errors = 0;

`ifdef PIO_SEQ_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    pio_seq_ctrl #(.DEPTH(8), .WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; the write lands on the next rising edge, returns at the following negedge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    initial begin
        pat[0] = 16'h1111; pat[1] = 16'h2222; pat[2] = 16'h3333;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        address = 2'd0; writedata = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_out", 32'(out_port), 32'h0);
        rd(2'd3, rv); chk("rst_status", rv, 32'h0000_0002);
        rd(2'd2, rv); chk("rst_ctrl", rv, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);

        // One-shot playback, dwell 4
        wr(2'd0, 32'h1111); wr(2'd0, 32'h2222); wr(2'd0, 32'h3333);
        wr(2'd1, 32'd4);
        wr(2'd2, 32'h1);
        chk("once_k0", 32'(out_port), 32'h0);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            exp_v = (k <= 4) ? 32'h1111 : (k <= 8) ? 32'h2222 : 32'h3333;
            chk($sformatf("once_k%0d", k), 32'(out_port), exp_v);
        end
        rd(2'd3, rv); chk("once_status", rv, 32'h0000_3008);
        rd(2'd2, rv); chk("once_ctrl", rv, 32'h0);
        rd(2'd0, rv); chk("once_data_rd", rv, 32'h3333);

        // Looped playback, then stop mid-word
        wr(2'd3, 32'h8);
        wr(2'd2, 32'h3);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            chk($sformatf("loop_k%0d", k), 32'(out_port), 32'(pat[((k - 1) / 4) % 3]));
        end
        wr(2'd2, 32'h0);
        repeat (5) @(negedge clk);
        chk("stop_out", 32'(out_port), 32'h1111);
        rd(2'd3, rv); chk("stop_status", rv, 32'h0000_3000);

        // Overflow: nine writes into eight entries
        wr(2'd2, 32'h8000_0000);
        rd(2'd3, rv); chk("flush_status", rv, 32'h0000_0002);
        for (int i = 1; i <= 9; i++) wr(2'd0, 32'h0A00 + 32'(i));
        rd(2'd3, rv); chk("ovf_status", rv, 32'h0000_8104);
        wr(2'd1, 32'd1);
        wr(2'd2, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_v = (k <= 8) ? (32'h0A00 + 32'(k)) : 32'h0A08;
            chk($sformatf("ovf_play_k%0d", k), 32'(out_port), exp_v);
        end
        rd(2'd3, rv); chk("ovf_done_status", rv, 32'h0000_810C);
        wr(2'd3, 32'h100);
        rd(2'd3, rv); chk("ovf_clr", rv, 32'h0000_800C);
        wr(2'd3, 32'h8);
        rd(2'd3, rv); chk("done_clr", rv, 32'h0000_8004);

        // Run with an empty buffer
        wr(2'd2, 32'h8000_0000);
        wr(2'd2, 32'h1);
        @(negedge clk);
        rd(2'd3, rv); chk("empty_run_status", rv, 32'h0000_000A);
        rd(2'd2, rv); chk("empty_run_ctrl", rv, 32'h0);
        chk("empty_run_out", 32'(out_port), 32'h0A08);
        wr(2'd3, 32'h8);

        // Zero dwell, two words, irq at done
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h0B01); wr(2'd0, 32'h0B02);
        wr(2'd2, 32'h5);
        @(negedge clk); chk("dw0_k1", 32'(out_port), 32'h0B01);
        @(negedge clk); chk("dw0_k2", 32'(out_port), 32'h0B02);
        chk("dw0_irq_k2", 32'(irq), 32'h0);
        @(negedge clk); chk("dw0_k3", 32'(out_port), 32'h0B02);
        chk("dw0_irq_done", 32'(irq), 32'(IRQ_ON));
        rd(2'd3, rv); chk("dw0_status", rv, 32'h0000_2008);
        rd(2'd2, rv); chk("dw0_ctrl", rv, IRQ_ON ? 32'h4 : 32'h0);
        wr(2'd3, 32'h8);
        chk("dw0_irq_clr", 32'(irq), 32'h0);
        rd(2'd3, rv); chk("dw0_status_clr", rv, 32'h0000_2000);

        // Asynchronous reset mid-play
        wr(2'd1, 32'd4);
        wr(2'd2, 32'h1);
        repeat (2) @(negedge clk);
        chk("pre_rst_out", 32'(out_port), 32'h0B01);
        reset_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(out_port), 32'h0);
        rd(2'd3, rv); chk("async_rst_status", rv, 32'h0000_0002);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Flush and run in the same write: flush wins
        wr(2'd0, 32'h0C01); wr(2'd0, 32'h0C02);
        wr(2'd2, 32'h8000_0001);
        repeat (3) @(negedge clk);
        rd(2'd3, rv); chk("flush_win_status", rv, 32'h0000_0002);
        rd(2'd2, rv); chk("flush_win_ctrl", rv, 32'h0);
        chk("flush_win_out", 32'(out_port), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
